// File: rtl/trivium_nlfsr_wide.sv
// One Trivium shift register (A, B or C) advancing W serial steps per enabled clock,
// with a handshaked three-word key/IV loader and a saturating warm-up step counter.
module trivium_nlfsr_wide #(
    parameter int REG_SZ        = 93,
    parameter int FEED_FWD_IDX  = 65,
    parameter int FEED_BKWD_IDX = 68,
    parameter int W             = 8,
    parameter int CONST_ONES    = 0,
    parameter int WARMUP_BITS   = 1152
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          ld_valid_i,
    output logic          ld_ready_o,
    input  logic [1:0]    ld_idx_i,
    input  logic [31:0]   ld_dat_i,
    input  logic [W-1:0]  fb_i,
    output logic [W-1:0]  fb_o,
    output logic [W-1:0]  ks_o,
    output logic          loaded_o,
    output logic          warm_done_o,
    output logic [15:0]   step_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        LOADED  = 2'd2
    } fsm_t;

    localparam int WARM_STEPS = (WARMUP_BITS + W - 1) / W;
    // Bits below 80 are key/IV words; the upper bits are cleared and the top CONST_ONES set on reload.
    localparam logic [REG_SZ-1:0] KEEP_LOW  = {REG_SZ{1'b1}} >> (REG_SZ - 80);
    localparam logic [REG_SZ-1:0] ONES_MASK = ~({REG_SZ{1'b1}} >> CONST_ONES);

    fsm_t               fsm_r, fsm_next_s;
    logic [REG_SZ-1:0]  state_r, state_next_s, shifted_s, reload_s;
    logic [2:0]         mask_r, mask_next_s, idx_bit_s;
    logic [15:0]        step_cnt_r, cnt_next_s;
    logic               warm_r, warm_next_s;
    logic               accept_s, word_ok_s, reached_s;
    logic [W-1:0]       ks_s, fb_s, in_rev_s;

    function automatic logic [REG_SZ-1:0] write_word(input logic [REG_SZ-1:0] s,
                                                     input logic [1:0]        idx,
                                                     input logic [31:0]       dat);
        logic [REG_SZ-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[31:0]  = dat;
            2'd1:    r[63:32] = dat;
            2'd2:    r[79:64] = dat[15:0];
            default: r = s;
        endcase
        return r;
    endfunction

    genvar k;
    for (k = 0; k < W; k++) begin : g_tap
        assign ks_s[k]         = state_r[REG_SZ-1-k] ^ state_r[FEED_FWD_IDX-k];
        assign fb_s[k]         = ks_s[k] ^ (state_r[REG_SZ-2-k] & state_r[REG_SZ-3-k]);
        // Serial step k lands at bit W-1-k so the oldest new bit sits highest.
        assign in_rev_s[W-1-k] = fb_i[k] ^ state_r[FEED_BKWD_IDX-k];
    end

    assign shifted_s = {state_r[REG_SZ-1-W:0], in_rev_s};
    assign reload_s  = (state_r & KEEP_LOW) | ONES_MASK;
    assign accept_s  = ld_valid_i & ~ce_i;
    assign word_ok_s = (ld_idx_i != 2'd3);
    assign reached_s = ({16'd0, step_cnt_r} >= 32'(WARM_STEPS));

    // Decode the load index into its completion-mask bit.
    always_comb begin
        idx_bit_s = 3'b000;
        case (ld_idx_i)
            2'd0:    idx_bit_s = 3'b001;
            2'd1:    idx_bit_s = 3'b010;
            2'd2:    idx_bit_s = 3'b100;
            default: idx_bit_s = 3'b000;
        endcase
    end

    // Load FSM, register stepping, step counter and warm-up flag next-state logic.
    always_comb begin
        state_next_s = state_r;
        fsm_next_s   = fsm_r;
        mask_next_s  = mask_r;
        cnt_next_s   = step_cnt_r;
        warm_next_s  = warm_r;
        case (fsm_r)
            EMPTY, LOADED: begin
                if (accept_s && word_ok_s) begin
                    state_next_s = write_word(reload_s, ld_idx_i, ld_dat_i);
                    mask_next_s  = idx_bit_s;
                    cnt_next_s   = 16'd0;
                    warm_next_s  = 1'b0;
                    fsm_next_s   = FILLING;
                end else begin
                    if ((fsm_r == LOADED) && ce_i) begin
                        state_next_s = shifted_s;
                        if (step_cnt_r != 16'hFFFF) begin
                            cnt_next_s = step_cnt_r + 16'd1;
                        end else begin
                            cnt_next_s = step_cnt_r;
                        end
                    end else begin
                        state_next_s = state_r;
                    end
                    if ((fsm_r == LOADED) && reached_s) begin
                        warm_next_s = 1'b1;
                    end else begin
                        warm_next_s = warm_r;
                    end
                end
            end
            FILLING: begin
                if (accept_s && word_ok_s) begin
                    state_next_s = write_word(state_r, ld_idx_i, ld_dat_i);
                    mask_next_s  = mask_r | idx_bit_s;
                    if ((mask_r | idx_bit_s) == 3'b111) begin
                        fsm_next_s = LOADED;
                    end else begin
                        fsm_next_s = FILLING;
                    end
                end else begin
                    fsm_next_s = FILLING;
                end
            end
            default: begin
                fsm_next_s  = EMPTY;
                mask_next_s = 3'b000;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_r      <= EMPTY;
            state_r    <= '0;
            mask_r     <= 3'b000;
            step_cnt_r <= 16'd0;
            warm_r     <= 1'b0;
        end else begin
            fsm_r      <= fsm_next_s;
            state_r    <= state_next_s;
            mask_r     <= mask_next_s;
            step_cnt_r <= cnt_next_s;
            warm_r     <= warm_next_s;
        end
    end

    assign ld_ready_o  = ~ce_i;
    assign ks_o        = ks_s;
    assign fb_o        = fb_s;
    assign loaded_o    = (fsm_r == LOADED);
    assign warm_done_o = warm_r;
    assign step_cnt_o  = step_cnt_r;

endmodule
